// File: rtl/keccak_round_sequencer.sv
// Keccak-f[1600] round sequencer: steps the round datapath through NUM_ROUNDS rounds
// over a valid/ready handshake, forming each iota constant on the fly from the 8-bit
// rc(t) LFSR instead of a lookup table.
module keccak_round_sequencer #(
    parameter int unsigned NUM_ROUNDS  = 24,
    parameter int unsigned FIRST_ROUND = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        round_valid,
    input  logic        round_ready,
    output logic [4:0]  round_number,
    output logic [63:0] round_constant,
    output logic        last_round,
    output logic        done
);

    // Reject parameter combinations that would run past round 23.
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 24 || FIRST_ROUND + NUM_ROUNDS > 24) begin : g_param_check
        $error("keccak_round_sequencer: illegal NUM_ROUNDS/FIRST_ROUND combination");
    end

    // One step of the rc(t) LFSR; the output bit is s[0] before the step.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
    endfunction

    // LFSR state at the start of round `first`: 7 steps per round from 8'h01.
    function automatic logic [7:0] lfsr_init(input int unsigned first);
        logic [7:0] s;
        s = 8'h01;
        for (int i = 0; i < 7 * int'(first); i++) begin
            s = lfsr_step(s);
        end
        return s;
    endfunction

    localparam logic [7:0] L0       = lfsr_init(FIRST_ROUND);
    localparam logic [4:0] FirstIdx = 5'(FIRST_ROUND);
    localparam logic [4:0] LastIdx  = 5'(FIRST_ROUND + NUM_ROUNDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  round_q, round_d;
    logic [7:0]  lfsr_q, lfsr_d;

    logic [7:0]  unroll [0:7];
    logic [63:0] rc;
    logic        handshake;

    // Seven-step LFSR unroll: outputs land on bits 2^j-1; unroll[7] is next round's state.
    always_comb begin
        rc        = '0;
        unroll[0] = lfsr_q;
        for (int j = 0; j < 7; j++) begin
            rc[(1 << j) - 1] = unroll[j][0];
            unroll[j + 1]    = lfsr_step(unroll[j]);
        end
    end

    assign handshake = (state_q == StRun) && round_ready;

    // Next-state logic; abort wins over a same-cycle handshake and over start.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        lfsr_d  = lfsr_q;
        unique case (state_q)
            StIdle: begin
                if (!abort && start) begin
                    state_d = StRun;
                    round_d = FirstIdx;
                    lfsr_d  = L0;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    round_d = FirstIdx;
                    lfsr_d  = L0;
                end else if (handshake) begin
                    if (round_q == LastIdx) begin
                        // Hold counter/LFSR on the last round; DONE reloads them.
                        state_d = StDone;
                    end else begin
                        round_d = round_q + 5'd1;
                        lfsr_d  = unroll[7];
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                round_d = FirstIdx;
                lfsr_d  = L0;
            end
            default: begin
                state_d = StIdle;
                round_d = FirstIdx;
                lfsr_d  = L0;
            end
        endcase
    end

    // State, round counter and LFSR registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            round_q <= FirstIdx;
            lfsr_q  <= L0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Outputs are pure functions of the registered state.
    always_comb begin
        busy           = (state_q == StRun);
        round_valid    = (state_q == StRun);
        last_round     = (state_q == StRun) && (round_q == LastIdx);
        done           = (state_q == StDone);
        round_number   = round_q;
        round_constant = rc;
    end

endmodule
